// File: rtl/counter_pkg.sv
// Shared types and command encodings for the counter controller.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] OP_START_ONESHOT  = 2'b00;
  localparam logic [1:0] OP_START_PERIODIC = 2'b01;
  localparam logic [1:0] OP_STOP           = 2'b10;
  localparam logic [1:0] OP_CLEAR          = 2'b11;

  // Both START ops share op[1] == 0; op[0] selects periodic.
  function automatic logic is_start(input logic [1:0] op);
    return (op[1] == 1'b0);
  endfunction

endpackage

// File: rtl/sync_counter.sv
// WIDTH-bit synchronous up-counter. Clear beats enable; wraps naturally.
module sync_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;

  // Count register: reset/clear to zero, otherwise increment when enabled.
  always_ff @(posedge clk) begin
    if (reset)    cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en)  cnt_q <= cnt_q + 1'b1;
  end

  assign q = cnt_q;

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven controller sequencing a sync_counter: load limit, run
// one-shot or periodic, stop and clear, with tc/busy/done status.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             mode_q, mode_d;   // 1 = periodic
  logic             done_q, done_d;
  logic             cnt_clr, cnt_en;
  logic             accept;

  sync_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .q     (q)
  );

  assign cmd_ready = (state_q != ST_LOAD) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign tc_pulse  = (state_q == ST_RUN) && (q == limit_q);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done      = done_q;

  // Control registers: state, latched limit/mode and sticky done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      limit_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Next state and counter control; an accepted command overrides the
  // terminal-count transition in the same cycle.
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    done_d  = done_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (accept) begin
      done_d = 1'b0;
      if (is_start(cmd_op)) begin
        state_d = ST_LOAD;
        limit_d = cmd_limit;
        mode_d  = cmd_op[0];
        cnt_clr = 1'b1;
      end else begin
        state_d = ST_IDLE;
        cnt_clr = (cmd_op == OP_CLEAR);
      end
    end else begin
      case (state_q)
        ST_LOAD: state_d = ST_RUN;
        ST_RUN: begin
          if (tc_pulse) begin
            if (mode_q) begin
              cnt_clr = 1'b1;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: each stimulus step pushes the outputs
// expected after the next edge; a monitor pops and compares every cycle.
module tb_counter_ctrl;

  localparam logic [1:0] OS = 2'b00, PER = 2'b01, STP = 2'b10, CLR = 2'b11;

  logic       clk = 0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_limit;
  logic [3:0] q;
  logic       busy, tc_pulse, done;

  typedef struct packed {
    logic [3:0] q;
    logic       busy;
    logic       tc;
    logic       done;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  counter_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_limit (cmd_limit),
    .q         (q),
    .busy      (busy),
    .tc_pulse  (tc_pulse),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, record the expected post-edge outputs.
  task automatic step(input logic r, input logic v, input logic [1:0] op,
                      input logic [3:0] lim, input logic [3:0] eq,
                      input logic eb, input logic et, input logic ed,
                      input logic er);
    exp_t e;
    reset = r; cmd_valid = v; cmd_op = op; cmd_limit = lim;
    e.q = eq; e.busy = eb; e.tc = et; e.done = ed; e.rdy = er;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic [3:0] eq, input logic eb, input logic et,
                      input logic ed, input logic er);
    step(1'b0, 1'b0, OS, 4'd0, eq, eb, et, ed, er);
  endtask

  // Monitor: one comparison per cycle once the post-edge outputs settle.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = '{q: q, busy: busy, tc: tc_pulse, done: done, rdy: cmd_ready};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL cyc%0d outputs: got q=%0d busy=%b tc=%b done=%b rdy=%b, want q=%0d busy=%b tc=%b done=%b rdy=%b",
                   cyc, got.q, got.busy, got.tc, got.done, got.rdy,
                   e.q, e.busy, e.tc, e.done, e.rdy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; cmd_valid = 0; cmd_op = OS; cmd_limit = 0;
    @(posedge clk); #2;
    // Reset state: ready low while reset held.
    step(1, 0, OS, 0, 0, 0, 0, 0, 0);
    step(1, 1, PER, 9, 0, 0, 0, 0, 0);   // command ignored under reset
    idle(0, 0, 0, 0, 1);

    // One-shot limit 5: LOAD, RUN 0..5, tc at 5, then sticky DONE.
    step(0, 1, OS, 5, 0, 1, 0, 0, 0);
    for (int k = 0; k <= 5; k++) idle(4'(k), 1, (k == 5), 0, 1);
    idle(5, 0, 0, 1, 1);
    idle(5, 0, 0, 1, 1);
    step(0, 1, CLR, 0, 0, 0, 0, 0, 1);   // CLEAR from DONE

    // Periodic limit 3, STOP presented while q == 2 on second lap.
    step(0, 1, PER, 3, 0, 1, 0, 0, 0);
    for (int i = 0; i <= 6; i++) idle(4'(i % 4), 1, ((i % 4) == 3), 0, 1);
    step(0, 1, STP, 0, 2, 0, 0, 0, 1);
    idle(2, 0, 0, 0, 1);

    // Periodic limit 15: full wrap, then reset held 2 cycles mid-RUN.
    step(0, 1, PER, 15, 0, 1, 0, 0, 0);
    for (int i = 0; i <= 17; i++) idle(4'(i % 16), 1, ((i % 16) == 15), 0, 1);
    step(1, 0, OS, 0, 0, 0, 0, 0, 0);
    step(1, 0, OS, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0, 1);

    // Periodic limit 0: tc every RUN cycle, q stays 0; then CLEAR.
    step(0, 1, PER, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle(0, 1, 1, 0, 1);
    step(0, 1, CLR, 0, 0, 0, 0, 0, 1);

    // One-shot limit 0: a single RUN cycle then DONE.
    step(0, 1, OS, 0, 0, 1, 0, 0, 0);
    idle(0, 1, 1, 0, 1);
    idle(0, 0, 0, 1, 1);

    // STOP in the one-shot tc cycle (limit 4): IDLE wins, done stays 0.
    step(0, 1, OS, 4, 0, 1, 0, 0, 0);
    for (int k = 0; k <= 4; k++) idle(4'(k), 1, (k == 4), 0, 1);
    step(0, 1, STP, 0, 4, 0, 0, 0, 1);
    idle(4, 0, 0, 0, 1);

    // START held through LOAD: blocked one cycle, re-accepted, q restarts.
    step(0, 1, PER, 7, 0, 1, 0, 0, 0);
    for (int k = 0; k <= 3; k++) idle(4'(k), 1, 0, 0, 1);
    step(0, 1, OS, 2, 0, 1, 0, 0, 0);    // accepted -> LOAD
    step(0, 1, OS, 2, 0, 1, 0, 0, 1);    // blocked in LOAD -> RUN
    step(0, 1, OS, 2, 0, 1, 0, 0, 0);    // re-accepted -> LOAD
    idle(0, 1, 0, 0, 1);
    idle(1, 1, 0, 0, 1);
    idle(2, 1, 1, 0, 1);
    idle(2, 0, 0, 1, 1);

    @(posedge clk); #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
